// File: rtl/proc_pipe.sv
`timescale 1ns/1ps
// Three-stage D/E/W datapath: decode register, execute register driving res,
// register-file write. E->D forwarding keeps FETCH/ADDR operands current.
module proc_pipe #(
  parameter int DW = 8,
  parameter int AW = 3,
  localparam int IW = 4 + AW + 2*DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic [DW-1:0] res,
  output logic          res_valid,
  output logic          carry,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_FET  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_ADDR = 4'd6;

  logic          d_valid_q;
  logic [3:0]    d_op_q;
  logic [AW-1:0] d_dst_q;
  logic [DW-1:0] d_a_q, d_b_q;

  logic [DW-1:0] res_q, res_d;
  logic          res_valid_q, res_valid_d;
  logic          carry_q, carry_d;
  logic [AW-1:0] e_dst_q;

  logic [DW-1:0] rf_q [2**AW];

  logic [AW-1:0] src_a, src_b;
  logic [DW-1:0] opnd_a, opnd_b;
  logic [DW:0]   sum_ab, diff_ab, sum_rr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid_q <= 1'b0;
      d_op_q    <= '0;
      d_dst_q   <= '0;
      d_a_q     <= '0;
      d_b_q     <= '0;
    end else begin
      d_valid_q <= instr_valid;
      if (instr_valid) begin
        d_op_q  <= instr[IW-1 -: 4];
        d_dst_q <= instr[2*DW +: AW];
        d_a_q   <= instr[DW +: DW];
        d_b_q   <= instr[0 +: DW];
      end
    end
  end

  // Only one instruction is ever younger than a pending write, so E is the
  // sole forwarding source; W has already landed by the time D reads.
  assign src_a  = d_a_q[AW-1:0];
  assign src_b  = d_b_q[AW-1:0];
  assign opnd_a = (res_valid_q && e_dst_q == src_a) ? res_q : rf_q[src_a];
  assign opnd_b = (res_valid_q && e_dst_q == src_b) ? res_q : rf_q[src_b];

  assign sum_ab  = {1'b0, d_a_q} + {1'b0, d_b_q};
  assign diff_ab = {1'b0, d_a_q} - {1'b0, d_b_q};
  assign sum_rr  = {1'b0, opnd_a} + {1'b0, opnd_b};

  always_comb begin
    res_d       = res_q;
    res_valid_d = 1'b0;
    carry_d     = carry_q;
    if (d_valid_q) begin
      res_valid_d = 1'b1;
      case (d_op_q)
        OP_AND:  res_d = d_a_q & d_b_q;
        OP_ADD:  {carry_d, res_d} = sum_ab;
        OP_FET:  res_d = opnd_a;
        OP_OR:   res_d = d_a_q | d_b_q;
        OP_XOR:  res_d = d_a_q ^ d_b_q;
        OP_SUB:  {carry_d, res_d} = diff_ab;
        OP_ADDR: {carry_d, res_d} = sum_rr;
        default: res_valid_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      e_dst_q     <= '0;
    end else begin
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      carry_q     <= carry_d;
      if (res_valid_d) e_dst_q <= d_dst_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) rf_q[i] <= '0;
    end else if (res_valid_q) begin
      rf_q[e_dst_q] <= res_q;
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign carry     = carry_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_proc_pipe.sv
`timescale 1ns/1ps
// Directed bench for proc_pipe: an in-order architectural model predicts each
// result at issue time and delays it to the visible pipeline timing.
module tb_proc_pipe;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int IW = 4 + AW + 2*DW;
  localparam int NR = 2**AW;

  logic          clk, rst_n;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [DW-1:0] res;
  logic          res_valid, carry;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int n_chk  = 0;
  int n_fail = 0;

  proc_pipe #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .res(res), .res_valid(res_valid), .carry(carry),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: m_arch is updated in program order at issue, m_vis
  // is what the debug port should show once the write has retired.
  logic [DW-1:0] m_arch [NR];
  logic [DW-1:0] m_vis  [NR];
  logic [3:0]    i_op;
  logic [AW-1:0] i_dst;
  logic [DW-1:0] i_a, i_b;
  logic [DW-1:0] m_res;
  logic          m_c, m_wr, m_cu;
  int            tmp;

  logic          md_v, md_cu, md_c;
  logic [DW-1:0] md_res;
  logic [AW-1:0] md_dst, me_dst;
  logic          exp_valid, exp_carry;
  logic [DW-1:0] exp_res;

  assign i_op  = instr[IW-1 -: 4];
  assign i_dst = instr[2*DW +: AW];
  assign i_a   = instr[DW +: DW];
  assign i_b   = instr[0 +: DW];

  always_comb begin
    m_res = '0;
    m_c   = 1'b0;
    tmp   = 0;
    m_wr  = instr_valid && (i_op <= 4'd6);
    m_cu  = instr_valid && (i_op == 4'd1 || i_op == 4'd5 || i_op == 4'd6);
    case (i_op)
      4'd0: m_res = i_a & i_b;
      4'd1: begin tmp = int'(i_a) + int'(i_b); m_res = tmp[DW-1:0]; m_c = tmp >= (1 << DW); end
      4'd2: m_res = m_arch[i_a % NR];
      4'd3: m_res = i_a | i_b;
      4'd4: m_res = i_a ^ i_b;
      4'd5: begin m_res = i_a - i_b; m_c = i_a < i_b; end
      4'd6: begin
        tmp = int'(m_arch[i_a % NR]) + int'(m_arch[i_b % NR]);
        m_res = tmp[DW-1:0];
        m_c = tmp >= (1 << DW);
      end
      default: m_res = '0;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        m_arch[i] <= '0;
        m_vis[i]  <= '0;
      end
      md_v <= 1'b0; md_cu <= 1'b0; md_c <= 1'b0; md_res <= '0; md_dst <= '0;
      exp_valid <= 1'b0; exp_res <= '0; exp_carry <= 1'b0; me_dst <= '0;
    end else begin
      if (exp_valid) m_vis[me_dst] <= exp_res;
      exp_valid <= md_v;
      if (md_v) begin
        exp_res <= md_res;
        me_dst  <= md_dst;
      end
      if (md_v && md_cu) exp_carry <= md_c;
      md_v   <= m_wr;
      md_cu  <= m_cu;
      md_c   <= m_c;
      md_res <= m_res;
      md_dst <= i_dst;
      if (m_wr) m_arch[i_dst] <= m_res;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("res_valid", 32'(res_valid), 32'(exp_valid));
      chk("res", 32'(res), 32'(exp_res));
      chk("carry", 32'(carry), 32'(exp_carry));
      chk("dbg_data", 32'(dbg_data), 32'(m_vis[dbg_addr]));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] dst,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic v);
    @(negedge clk);
    #1;
    instr       = {op, dst, a, b};
    instr_valid = v;
  endtask

  task automatic bubble();
    issue(4'd0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; dbg_addr = '0;
    #1;
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_dbg", 32'(dbg_data), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;

    // ADD 200+100 -> 44 with carry, visible in r3 one cycle later
    dbg_addr = 3'd3;
    issue(4'd1, 3'd3, 8'd200, 8'd100, 1'b1); bubble();
    @(negedge clk);
    chk("add_res", 32'(res), 32'd44);
    chk("add_carry", 32'(carry), 32'd1);
    chk("add_valid", 32'(res_valid), 32'd1);
    chk("add_dbg_old", 32'(dbg_data), 32'd0);
    @(negedge clk);
    chk("add_dbg_new", 32'(dbg_data), 32'd44);

    // back-to-back forward into FETCH
    issue(4'd1, 3'd1, 8'd5, 8'd6, 1'b1); issue(4'd2, 3'd2, 8'd1, 8'd0, 1'b1); bubble();
    dbg_addr = 3'd2;
    @(negedge clk);
    chk("fwd_fetch", 32'(res), 32'd11);
    @(negedge clk);
    chk("fwd_fetch_r2", 32'(dbg_data), 32'd11);

    // ADDR through register file after one bubble
    issue(4'd1, 3'd4, 8'd3, 8'd4, 1'b1); bubble(); issue(4'd6, 3'd5, 8'd4, 8'd4, 1'b1); bubble();
    @(negedge clk);
    chk("addr_rf", 32'(res), 32'd14);
    chk("addr_rf_c", 32'(carry), 32'd0);

    // SUB borrow, then AND leaves carry alone
    issue(4'd5, 3'd6, 8'd3, 8'd5, 1'b1); bubble();
    @(negedge clk);
    chk("sub_res", 32'(res), 32'd254);
    chk("sub_borrow", 32'(carry), 32'd1);
    issue(4'd0, 3'd7, 8'hF0, 8'h3C, 1'b1); bubble();
    @(negedge clk);
    chk("and_res", 32'(res), 32'h30);
    chk("and_carry", 32'(carry), 32'd1);

    // NOP opcode and invalid issue leave r0 and res untouched
    dbg_addr = 3'd0;
    issue(4'd4, 3'd0, 8'hAA, 8'h55, 1'b1); bubble();
    @(negedge clk);
    chk("xor_res", 32'(res), 32'hFF);
    issue(4'd9, 3'd0, 8'd1, 8'd2, 1'b1); bubble();
    @(negedge clk);
    chk("nop_valid", 32'(res_valid), 32'd0);
    chk("nop_hold", 32'(res), 32'hFF);
    @(negedge clk);
    chk("nop_r0", 32'(dbg_data), 32'hFF);
    issue(4'd1, 3'd0, 8'd1, 8'd1, 1'b0); bubble();
    @(negedge clk);
    chk("inv_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("inv_r0", 32'(dbg_data), 32'hFF);

    // ADDR with both operands forwarded from E
    issue(4'd1, 3'd6, 8'd10, 8'd20, 1'b1); issue(4'd6, 3'd7, 8'd6, 8'd6, 1'b1); bubble();
    @(negedge clk);
    chk("addr_fwd_same", 32'(res), 32'd60);
    issue(4'd1, 3'd1, 8'd250, 8'd0, 1'b1); bubble();
    @(negedge clk);
    issue(4'd6, 3'd2, 8'd1, 8'd1, 1'b1); bubble();
    @(negedge clk);
    chk("addr_wrap", 32'(res), 32'd244);
    chk("addr_wrap_c", 32'(carry), 32'd1);
    issue(4'd2, 3'd3, 8'hF9, 8'd0, 1'b1); bubble();
    @(negedge clk);
    chk("fetch_hi_ign", 32'(res), 32'd250);

    // reset pulse with ADD in flight
    issue(4'd1, 3'd5, 8'd1, 8'd1, 1'b1); bubble();
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("pulse_res", 32'(res), 32'd0);
    chk("pulse_valid", 32'(res_valid), 32'd0);
    chk("pulse_carry", 32'(carry), 32'd0);
    #0.5;
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      @(negedge clk);
      chk("post_rst_rf", 32'(dbg_data), 32'd0);
      chk("post_rst_valid", 32'(res_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
